// File: rtl/hwag_injector_pulse.sv
// hwag_injector_pulse: angle-triggered, time-terminated injector pulse generator.
// A pulse starts on the clock after acnt_data matches the shadowed start angle and
// lasts exactly sh_width enabled clk cycles. Shadows are frozen while a pulse runs,
// so reprogramming only affects the next pulse.
// Optional build macro: HWAG_INJ_PULSE_CNT_EN adds a 16-bit completed-pulse counter
// on output inj_cnt (cleared by ovr_clr).
module hwag_injector_pulse #(
    parameter int ANGLE_W   = 24,
    parameter int TIME_W    = 24,
    parameter int ANGLE_TOP = 3839
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic               hwag_start,
    input  logic               acnt_ena,
    input  logic [ANGLE_W-1:0] acnt_data,
    input  logic [ANGLE_W-1:0] start_angle,
    input  logic [TIME_W-1:0]  pulse_width,
    input  logic               ovr_clr,
    output logic               inj_out,
    output logic               busy,
    output logic               overrun
`ifdef HWAG_INJ_PULSE_CNT_EN
    ,
    output logic [15:0]        inj_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        ACTIVE  = 2'd2,
        HOLDOFF = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TIME_W-1:0]  timer_q, timer_d;
    logic [ANGLE_W-1:0] sh_angle_q, sh_angle_d;
    logic [TIME_W-1:0]  sh_width_q, sh_width_d;
    logic               inj_q, inj_d;
    logic               ovr_q, ovr_d;

    // Angle match against the shadowed start angle; an out-of-range start angle never
    // matches, so a channel programmed beyond the top of the revolution stays silent.
    logic angle_hit;
    logic angle_valid;
    assign angle_valid = (sh_angle_q <= ANGLE_W'(ANGLE_TOP));
    assign angle_hit   = acnt_ena && (acnt_data == sh_angle_q) && angle_valid;

`ifdef HWAG_INJ_PULSE_CNT_EN
    logic [15:0] cnt_q, cnt_d;
`endif

    // Next-state, timer, shadow, output and flag logic; everything holds when ena=0.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        sh_angle_d = sh_angle_q;
        sh_width_d = sh_width_q;
        inj_d      = inj_q;
        ovr_d      = ovr_q;
`ifdef HWAG_INJ_PULSE_CNT_EN
        cnt_d      = cnt_q;
`endif
        if (ena) begin
            if (ovr_clr) begin
                ovr_d = 1'b0;
`ifdef HWAG_INJ_PULSE_CNT_EN
                cnt_d = 16'd0;
`endif
            end

            // Shadows track the programming registers except during a pulse.
            if (state_q != ACTIVE) begin
                sh_angle_d = start_angle;
                sh_width_d = pulse_width;
            end

            case (state_q)
                IDLE: begin
                    if (hwag_start) begin
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (angle_hit && (sh_width_q != '0)) begin
                        state_d = ACTIVE;
                        timer_d = sh_width_q;
                        inj_d   = 1'b1;
                    end
                end
                ACTIVE: begin
                    // A second hit during the pulse is flagged but never restarts it.
                    if (angle_hit) begin
                        ovr_d = 1'b1;
                    end
                    if (timer_q != '0) begin
                        timer_d = timer_q - 1'b1;
                    end
                    if (timer_q == TIME_W'(1)) begin
                        state_d = HOLDOFF;
                        inj_d   = 1'b0;
`ifdef HWAG_INJ_PULSE_CNT_EN
                        cnt_d   = cnt_d + 16'd1;
`endif
                    end
                end
                HOLDOFF: begin
                    // Wait for the angle to move on so one angle step fires only once.
                    if (acnt_data != sh_angle_q) begin
                        state_d = ARMED;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // Losing angle sync wins over everything and truncates a running pulse.
            if (!hwag_start) begin
                state_d = IDLE;
                timer_d = '0;
                inj_d   = 1'b0;
`ifdef HWAG_INJ_PULSE_CNT_EN
                if (ovr_clr) begin
                    cnt_d = 16'd0;
                end else begin
                    cnt_d = cnt_q;
                end
`endif
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            sh_angle_q <= '0;
            sh_width_q <= '0;
            inj_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            sh_angle_q <= sh_angle_d;
            sh_width_q <= sh_width_d;
            inj_q      <= inj_d;
            ovr_q      <= ovr_d;
        end
    end

`ifdef HWAG_INJ_PULSE_CNT_EN
    // Completed-pulse counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
    assign inj_cnt = cnt_q;
`endif

    assign inj_out = inj_q;
    assign busy    = (state_q == ACTIVE);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_hwag_injector_pulse.sv
// Directed bench for hwag_injector_pulse: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences (full revolution, zero width, overrun with wrap,
// truncation, reprogramming during a pulse, ena freeze and reset).
module tb_hwag_injector_pulse;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        hwag_start;
    logic        acnt_ena;
    logic [23:0] acnt_data;
    logic [23:0] start_angle;
    logic [23:0] pulse_width;
    logic        ovr_clr;
    logic        inj_out;
    logic        busy;
    logic        overrun;
`ifdef HWAG_INJ_PULSE_CNT_EN
    logic [15:0] inj_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hwag_injector_pulse #(
        .ANGLE_W  (24),
        .TIME_W   (24),
        .ANGLE_TOP(3839)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .hwag_start (hwag_start),
        .acnt_ena   (acnt_ena),
        .acnt_data  (acnt_data),
        .start_angle(start_angle),
        .pulse_width(pulse_width),
        .ovr_clr    (ovr_clr),
        .inj_out    (inj_out),
        .busy       (busy),
        .overrun    (overrun)
`ifdef HWAG_INJ_PULSE_CNT_EN
        ,
        .inj_cnt    (inj_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        ena;
        logic        hs;
        logic        aen;
        logic [23:0] acnt;
        logic [23:0] sa;
        logic [23:0] pw;
        logic        clr;
        logic        e_inj;
        logic        e_ovr;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic arm(input logic [23:0] sa, input logic [23:0] pw);
        hwag_start  = 1'b1;
        ena         = 1'b1;
        acnt_ena    = 1'b0;
        acnt_data   = 24'd0;
        ovr_clr     = 1'b0;
        start_angle = sa;
        pulse_width = pw;
        step();
        step();
    endtask

    task automatic trigger(input logic [23:0] sa);
        acnt_data = sa;
        acnt_ena  = 1'b1;
        step();
        acnt_ena  = 1'b0;
    endtask

    initial begin
        int high;
        int rise_at;
        int len;
        int hits;
        logic stayed;
        logic [23:0] a;

        rst = 1'b1; ena = 1'b0; hwag_start = 1'b0; acnt_ena = 1'b0;
        acnt_data = '0; start_angle = '0; pulse_width = '0; ovr_clr = 1'b0;

        //          rst ena hs aen acnt  sa    pw clr inj ovr
        vecs[0]  = '{1, 1, 0, 0, 0,    20,   3, 0, 0, 0};  // reset state
        vecs[1]  = '{0, 1, 1, 1, 19,   20,   3, 0, 0, 0};  // IDLE -> ARMED
        vecs[2]  = '{0, 1, 1, 1, 20,   20,   3, 0, 1, 0};  // match -> pulse on
        vecs[3]  = '{0, 1, 1, 0, 20,   20,   3, 0, 1, 0};
        vecs[4]  = '{0, 1, 1, 1, 21,   20,   3, 0, 1, 0};
        vecs[5]  = '{0, 1, 1, 0, 21,   20,   3, 0, 0, 0};  // 3 cycles done
        vecs[6]  = '{0, 1, 1, 0, 21,   20,   3, 0, 0, 0};  // HOLDOFF -> ARMED
        vecs[7]  = '{0, 0, 1, 1, 20,   20,   3, 0, 0, 0};  // ena=0 freezes
        vecs[8]  = '{0, 1, 1, 0, 20,   20,   0, 0, 0, 0};  // no acnt_ena, width->0
        vecs[9]  = '{0, 1, 1, 1, 20,   20,   0, 0, 0, 0};  // width 0 ignored
        vecs[10] = '{0, 1, 1, 1, 20,   20,   2, 0, 0, 0};  // shadow still 0
        vecs[11] = '{0, 1, 1, 1, 20,   20,   2, 0, 1, 0};  // pulse on
        vecs[12] = '{0, 1, 1, 1, 20,   20,   2, 0, 1, 1};  // re-hit -> overrun
        vecs[13] = '{0, 1, 1, 0, 20,   20,   2, 1, 0, 0};  // end + clear
        vecs[14] = '{0, 1, 1, 1, 20,   20,   2, 0, 0, 0};  // HOLDOFF no retrigger
        vecs[15] = '{0, 1, 1, 1, 21,   20,   2, 0, 0, 0};  // -> ARMED
        vecs[16] = '{0, 1, 0, 1, 20,   20,   2, 0, 0, 0};  // hs=0 -> IDLE
        vecs[17] = '{0, 1, 1, 1, 20,   20,   2, 0, 0, 0};  // IDLE -> ARMED
        vecs[18] = '{0, 1, 1, 1, 20,   20,   2, 0, 1, 0};  // pulse on
        vecs[19] = '{0, 1, 1, 1, 20,   20,   2, 1, 1, 1};  // set beats clear
        vecs[20] = '{1, 1, 1, 1, 20,   20,   2, 0, 0, 0};  // reset
        vecs[21] = '{0, 1, 1, 0, 0,    4000, 5, 0, 0, 0};  // out-of-range angle
        vecs[22] = '{0, 1, 1, 1, 4000, 4000, 5, 0, 0, 0};  // never matches
        vecs[23] = '{0, 1, 1, 1, 4000, 4000, 5, 0, 0, 0};

        for (int i = 0; i < 24; i++) begin
            rst         = vecs[i].rst;
            ena         = vecs[i].ena;
            hwag_start  = vecs[i].hs;
            acnt_ena    = vecs[i].aen;
            acnt_data   = vecs[i].acnt;
            start_angle = vecs[i].sa;
            pulse_width = vecs[i].pw;
            ovr_clr     = vecs[i].clr;
            step();
            $display("vec %0d: inj_out=%0d busy=%0d overrun=%0d", i, inj_out, busy, overrun);
            check($sformatf("vec%0d inj_out", i), 32'(inj_out), 32'(vecs[i].e_inj));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].e_inj));
            check($sformatf("vec%0d overrun", i), 32'(overrun), 32'(vecs[i].e_ovr));
        end
        rst = 1'b0; ovr_clr = 1'b0;

        // Test 1: full revolution, start 100, width 50.
        do_reset();
        arm(24'd100, 24'd50);
        high = 0; rise_at = -1;
        for (int i = 0; i < 3840; i++) begin
            acnt_data = 24'(i);
            acnt_ena  = 1'b1;
            step();
            if (inj_out) begin
                if (rise_at < 0) rise_at = i;
                high++;
            end
        end
        acnt_ena = 1'b0;
        $display("t1: rise at acnt=%0d, high %0d cycles", rise_at, high);
        check("t1 rise angle", 32'(rise_at), 32'd100);
        check("t1 high cycles", 32'(high), 32'd50);
        check("t1 overrun", 32'(overrun), 32'd0);
`ifdef HWAG_INJ_PULSE_CNT_EN
        check("t1 inj_cnt", 32'(inj_cnt), 32'd1);
`endif

        // Test 2: width 0 disables the channel.
        do_reset();
        arm(24'd100, 24'd0);
        high = 0;
        for (int i = 0; i < 3840; i++) begin
            acnt_data = 24'(i);
            acnt_ena  = 1'b1;
            step();
            if (inj_out || busy) high++;
        end
        acnt_ena = 1'b0;
        $display("t2: high %0d cycles", high);
        check("t2 never high", 32'(high), 32'd0);

        // Test 3: width 1000, angle steps 5 per clk so a revolution (with wrap) is
        // 768 clks and angle 10 is hit again mid-pulse.
        do_reset();
        arm(24'd10, 24'd1000);
        high = 0; rise_at = -1; hits = 0;
        for (int i = 0; i < 1200; i++) begin
            a = 24'((5 * i) % 3840);
            acnt_data = a;
            acnt_ena  = 1'b1;
            if (a == 24'd10) hits++;
            step();
            if (inj_out) begin
                if (rise_at < 0) rise_at = i;
                high++;
            end
            if (i == 769) check("t3 overrun before 2nd hit", 32'(overrun), 32'd0);
            if (i == 770) check("t3 overrun on 2nd hit", 32'(overrun), 32'd1);
        end
        acnt_ena = 1'b0;
        $display("t3: hits %0d, rise at clk %0d, high %0d cycles, overrun=%0d", hits, rise_at, high, overrun);
        check("t3 rise clk", 32'(rise_at), 32'd2);
        check("t3 high cycles", 32'(high), 32'd1000);
        check("t3 overrun sticky", 32'(overrun), 32'd1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("t3 overrun cleared", 32'(overrun), 32'd0);
`ifdef HWAG_INJ_PULSE_CNT_EN
        check("t3 inj_cnt cleared", 32'(inj_cnt), 32'd0);
`endif

        // Test 4: drop hwag_start 20 cycles into a 200-cycle pulse.
        do_reset();
        arm(24'd50, 24'd200);
        trigger(24'd50);
        check("t4 pulse on", 32'(inj_out), 32'd1);
        for (int i = 0; i < 19; i++) step();
        check("t4 still on at 20", 32'(inj_out), 32'd1);
        hwag_start = 1'b0;
        step();
        $display("t4: after hwag_start drop inj_out=%0d busy=%0d", inj_out, busy);
        check("t4 truncated inj_out", 32'(inj_out), 32'd0);
        check("t4 truncated busy", 32'(busy), 32'd0);
        acnt_data = 24'd50; acnt_ena = 1'b1;
        step();
        acnt_ena = 1'b0;
        check("t4 idle no trigger", 32'(inj_out), 32'd0);
`ifdef HWAG_INJ_PULSE_CNT_EN
        check("t4 inj_cnt", 32'(inj_cnt), 32'd0);
`endif

        // Test 5: width reprogrammed 50->80 mid-pulse affects only the next pulse.
        do_reset();
        arm(24'd30, 24'd50);
        trigger(24'd30);
        len = (inj_out) ? 1 : 0;
        for (int i = 0; i < 2000 && len > 0; i++) begin
            if (len == 10) pulse_width = 24'd80;
            step();
            if (!inj_out) break;
            len++;
        end
        $display("t5: first pulse %0d cycles", len);
        check("t5 first pulse", 32'(len), 32'd50);
        arm(24'd30, 24'd80);
        trigger(24'd30);
        len = (inj_out) ? 1 : 0;
        for (int i = 0; i < 2000 && len > 0; i++) begin
            step();
            if (!inj_out) break;
            len++;
        end
        $display("t5: second pulse %0d cycles", len);
        check("t5 second pulse", 32'(len), 32'd80);

        // Test 6: ena=0 stretches the pulse, then reset mid-pulse with ena=0.
        do_reset();
        arm(24'd40, 24'd20);
        trigger(24'd40);
        len = (inj_out) ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (inj_out) len++;
        end
        ena = 1'b0;
        stayed = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (inj_out) len++; else stayed = 1'b0;
        end
        ena = 1'b1;
        check("t6 frozen high", 32'(stayed), 32'd1);
        for (int i = 0; i < 100; i++) begin
            step();
            if (!inj_out) break;
            len++;
        end
        $display("t6: stretched pulse %0d cycles", len);
        check("t6 stretched pulse", 32'(len), 32'd27);
        arm(24'd40, 24'd20);
        trigger(24'd40);
        step(); step(); step();
        check("t6 on before reset", 32'(inj_out), 32'd1);
        ena = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("t6: after reset inj_out=%0d busy=%0d overrun=%0d", inj_out, busy, overrun);
        check("t6 reset inj_out", 32'(inj_out), 32'd0);
        check("t6 reset busy", 32'(busy), 32'd0);
        check("t6 reset overrun", 32'(overrun), 32'd0);
`ifdef HWAG_INJ_PULSE_CNT_EN
        check("t6 reset inj_cnt", 32'(inj_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
